pic_alu_seq: RTL and testbench

Parametrised, handshaked successor to the PIC core ALU. It executes one operation per request on WIDTH-bit operands and registers the result and status flags. It adds subtract, add-with-carry, and an iterative unsigned multiply that takes WIDTH cycles. It sits between the instruction decoder and the register-file write-back, which accepts the result and status flags through a valid/ready pair.

---
 rtl/pic_alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_pic_alu_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pic_alu_seq.sv
// pic_alu_seq: handshaked PIC-style ALU. Single-cycle ops register their
// result on the accepting edge. MUL runs a WIDTH-step shift-add. Results and
// flags are held in DONE until the write-back side takes them.
module pic_alu_seq #(
    parameter int WIDTH = 8,
    parameter int BIT_W = $clog2(WIDTH)
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [3:0]         Instruction,
    input  logic [WIDTH-1:0]   In1,
    input  logic [WIDTH-1:0]   In2,
    input  logic [BIT_W-1:0]   Bit,
    input  logic               Carry_In,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [WIDTH-1:0]   Out,
    output logic [WIDTH-1:0]   Out_High,
    output logic               Zero,
    output logic               Carry,
    output logic               DecimalCarry
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDC  = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_RLF   = 4'd6;
    localparam logic [3:0] OP_RRF   = 4'd7;
    localparam logic [3:0] OP_SWAP  = 4'd8;
    localparam logic [3:0] OP_BSF   = 4'd9;
    localparam logic [3:0] OP_BCF   = 4'd10;
    localparam logic [3:0] OP_BTEST = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    localparam int HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE_C   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BIT_W:0]   WIDTH_C = (BIT_W+1)'(WIDTH);
    localparam logic [BIT_W-1:0] LAST_C  = BIT_W'(WIDTH-1);
    localparam logic [BIT_W-1:0] INC_C   = BIT_W'(1);

    logic [1:0]           state_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [WIDTH-1:0]     out_r;
    logic [WIDTH-1:0]     out_high_r;
    logic                 zero_r;
    logic                 carry_r;
    logic                 dc_r;
    logic [WIDTH-1:0]     mcand_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [BIT_W-1:0]     cnt_r;

    logic [WIDTH-1:0]     b_s;
    logic                 cin_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH-1:0]     mask_s;
    logic [WIDTH-1:0]     res_s;
    logic                 c_s;
    logic                 dc_s;
    logic [WIDTH:0]       partial_s;
    logic [2*WIDTH-1:0]   acc_next_s;

    // Single-cycle datapath: one shared adder (SUB uses ~In2 + 1) and result mux.
    always_comb begin
        b_s    = In2;
        cin_s  = 1'b0;
        case (Instruction)
            OP_ADDC: cin_s = Carry_In;
            OP_SUB: begin
                b_s   = ~In2;
                cin_s = 1'b1;
            end
            default: cin_s = 1'b0;
        endcase
        sum_s  = {1'b0, In1} + {1'b0, b_s} + {{WIDTH{1'b0}}, cin_s};
        // Out-of-range bit indices (non power-of-two WIDTH) select nothing.
        mask_s = ({1'b0, Bit} < WIDTH_C) ? (ONE_C << Bit) : {WIDTH{1'b0}};
        res_s  = {WIDTH{1'b0}};
        c_s    = 1'b0;
        dc_s   = 1'b0;
        case (Instruction)
            OP_ADD, OP_ADDC, OP_SUB: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                dc_s  = sum_s[4] ^ In1[4] ^ b_s[4];
            end
            OP_AND:   res_s = In1 & In2;
            OP_OR:    res_s = In1 | In2;
            OP_XOR:   res_s = In1 ^ In2;
            OP_RLF: begin
                res_s = {In1[WIDTH-2:0], Carry_In};
                c_s   = In1[WIDTH-1];
            end
            OP_RRF: begin
                res_s = {Carry_In, In1[WIDTH-1:1]};
                c_s   = In1[0];
            end
            OP_SWAP:  res_s = {In1[HALF-1:0], In1[WIDTH-1:HALF]};
            OP_BSF:   res_s = In1 | mask_s;
            OP_BCF:   res_s = In1 & ~mask_s;
            OP_BTEST: res_s = In1 & mask_s;
            default:  res_s = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add step: add multiplicand into the high half if the current
    // multiplier LSB is set, then shift the whole accumulator right.
    always_comb begin
        partial_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        acc_next_s = {partial_s, acc_r[WIDTH-1:1]};
    end

    // Control FSM plus registered result, flags and handshake outputs.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_r       <= {WIDTH{1'b0}};
            out_high_r  <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            dc_r        <= 1'b0;
            mcand_r     <= {WIDTH{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            cnt_r       <= {BIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (In_Valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        if (Instruction == OP_MUL) begin
                            mcand_r <= In1;
                            acc_r   <= {{WIDTH{1'b0}}, In2};
                            cnt_r   <= {BIT_W{1'b0}};
                            state_r <= ST_MUL;
                        end else begin
                            out_r       <= res_s;
                            out_high_r  <= {WIDTH{1'b0}};
                            zero_r      <= ~|res_s;
                            carry_r     <= c_s;
                            dc_r        <= dc_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + INC_C;
                    if (cnt_r == LAST_C) begin
                        out_r       <= acc_next_s[WIDTH-1:0];
                        out_high_r  <= acc_next_s[2*WIDTH-1:WIDTH];
                        zero_r      <= ~|acc_next_s;
                        carry_r     <= 1'b0;
                        dc_r        <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (Out_Ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign In_Ready     = in_ready_r;
    assign Out_Valid    = out_valid_r;
    assign Out          = out_r;
    assign Out_High     = out_high_r;
    assign Zero         = zero_r;
    assign Carry        = carry_r;
    assign DecimalCarry = dc_r;

endmodule

// File: tb/tb_pic_alu_seq.sv
// Directed scoreboard bench for pic_alu_seq (WIDTH=8).
module tb_pic_alu_seq;

    logic       clk;
    logic       nreset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] instr;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [2:0] bitx;
    logic       carry_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_lo;
    logic [7:0] out_hi;
    logic       zero;
    logic       carry;
    logic       dcarry;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       z;
        logic       c;
        logic       dc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    pic_alu_seq #(.WIDTH(8)) dut (
        .Clk(clk), .nReset(nreset), .In_Valid(in_valid), .In_Ready(in_ready),
        .Instruction(instr), .In1(in1), .In2(in2), .Bit(bitx),
        .Carry_In(carry_in), .Out_Valid(out_valid), .Out_Ready(out_ready),
        .Out(out_lo), .Out_High(out_hi), .Zero(zero), .Carry(carry),
        .DecimalCarry(dcarry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency and scoreboard result, optionally stall
    // in DONE while waving garbage requests, then complete the handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] bi, input logic ci,
                          input exp_t e, input int exp_lat, input int stall);
        exp_t got;
        exp_t held;
        int   lat;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        instr    = op;
        in1      = a;
        in2      = b;
        bitx     = bi;
        carry_in = ci;
        in_valid = 1'b1;
        sb_q.push_back(e);
        lat = 0;
        do begin
            tick();
            lat++;
            in_valid = 1'b0;
            in1      = 8'($urandom);
            in2      = 8'($urandom);
            bitx     = 3'($urandom);
            carry_in = 1'($urandom);
            if (!out_valid && op == 4'd12)
                check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
        end while (!out_valid && lat < 40);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got  = {out_lo, out_hi, zero, carry, dcarry};
            held = sb_q.pop_front();
            check({tag, "_out"},  {24'd0, got.lo}, {24'd0, held.lo});
            check({tag, "_high"}, {24'd0, got.hi}, {24'd0, held.hi});
            check({tag, "_flags"}, {29'd0, got.z, got.c, got.dc}, {29'd0, held.z, held.c, held.dc});
        end
        for (int s = 0; s < stall; s++) begin
            in_valid = ~in_valid;
            instr    = 4'($urandom);
            in1      = 8'($urandom);
            in2      = 8'($urandom);
            tick();
            check({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_stall_hold"}, {13'd0, out_lo, out_hi, zero, carry, dcarry},
                  {13'd0, e.lo, e.hi, e.z, e.c, e.dc});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_release_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        nreset    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 4'd0;
        in1       = 8'd0;
        in2       = 8'd0;
        bitx      = 3'd0;
        carry_in  = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_outputs", {13'd0, out_valid, out_lo, out_hi, zero, carry, dcarry}, 32'd0);
        nreset = 1'b1;
        tick();
        check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

        //                         lo     hi     z     c     dc
        run_op("add",   4'd0,  8'h3A, 8'hC6, 3'd0, 1'b0, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b1}, 1, 0);
        run_op("sub1",  4'd2,  8'h10, 8'h01, 3'd0, 1'b0, '{8'h0F, 8'h00, 1'b0, 1'b1, 1'b0}, 1, 0);
        run_op("sub2",  4'd2,  8'h01, 8'h02, 3'd0, 1'b0, '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("addc",  4'd1,  8'h0F, 8'h00, 3'd0, 1'b1, '{8'h10, 8'h00, 1'b0, 1'b0, 1'b1}, 1, 0);
        run_op("mul_ff",4'd12, 8'hFF, 8'hFF, 3'd0, 1'b1, '{8'h01, 8'hFE, 1'b0, 1'b0, 1'b0}, 9, 0);
        run_op("mul_sm",4'd12, 8'h0D, 8'h0B, 3'd0, 1'b0, '{8'h8F, 8'h00, 1'b0, 1'b0, 1'b0}, 9, 0);
        run_op("mul_0", 4'd12, 8'h00, 8'h5A, 3'd0, 1'b0, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0}, 9, 0);
        run_op("rlf",   4'd6,  8'h80, 8'h00, 3'd0, 1'b0, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0}, 1, 0);
        run_op("rrf",   4'd7,  8'h01, 8'h00, 3'd0, 1'b1, '{8'h80, 8'h00, 1'b0, 1'b1, 1'b0}, 1, 0);
        run_op("btst5", 4'd11, 8'h20, 8'h00, 3'd5, 1'b0, '{8'h20, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("btst4", 4'd11, 8'h20, 8'h00, 3'd4, 1'b0, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0}, 1, 0);
        run_op("and",   4'd3,  8'hF0, 8'h3C, 3'd0, 1'b1, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("or",    4'd4,  8'hF0, 8'h3C, 3'd0, 1'b1, '{8'hFC, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("xor",   4'd5,  8'hF0, 8'h3C, 3'd0, 1'b1, '{8'hCC, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("swap",  4'd8,  8'hA5, 8'h00, 3'd0, 1'b0, '{8'h5A, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("bsf",   4'd9,  8'h00, 8'h00, 3'd7, 1'b0, '{8'h80, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("bcf",   4'd10, 8'hFF, 8'h00, 3'd0, 1'b0, '{8'hFE, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        run_op("op14",  4'd14, 8'hFF, 8'hFF, 3'd0, 1'b1, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0}, 1, 0);
        run_op("stall", 4'd0,  8'h05, 8'h03, 3'd0, 1'b0, '{8'h08, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 5);
        check("stall_no_extra", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a multiply: no result, clean restart.
        instr    = 4'd12;
        in1      = 8'hFF;
        in2      = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("rstmul_busy", {30'd0, out_valid, in_ready}, 32'd0);
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        check("rstmul_outputs", {13'd0, out_valid, out_lo, out_hi, zero, carry, dcarry}, 32'd0);
        check("rstmul_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        check("rstmul_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstmul_no_result", {31'd0, out_valid}, 32'd0);
        run_op("post_add", 4'd0, 8'h01, 8'h01, 3'd0, 1'b0, '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0}, 1, 0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
